// File: rtl/fmac_driver.sv
// fmac_driver: sequences one SpMV row at a time onto the fmac accumulate
// interface. Element beats pass straight through to the fmac input, done
// acknowledgements are tracked, and at row end the accumulator is read,
// cleared and presented as a single row result. Payload bits are never
// interpreted.
module fmac_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_WIDTH-1:0]    row_nnz,
    input  logic                    row_valid,
    output logic                    row_ready,
    input  logic [2*DATA_WIDTH-1:0] elem_val,
    input  logic [DATA_WIDTH-1:0]   elem_mult,
    input  logic                    elem_valid,
    output logic                    elem_ready,
    output logic [2*DATA_WIDTH-1:0] mac_val,
    output logic [DATA_WIDTH-1:0]   mac_mult,
    output logic                    mac_in_valid,
    input  logic                    mac_in_ready,
    output logic                    mac_reset,
    input  logic [2*DATA_WIDTH-1:0] mac_acc,
    input  logic                    mac_valid,
    output logic                    mac_ready,
    input  logic                    mac_done,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_READ   = 3'd4,
        S_CLEAR  = 3'd5,
        S_OUT    = 3'd6
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CNT_WIDTH-1:0]    remaining_r;
    logic [CNT_WIDTH-1:0]    outstanding_r;
    logic [CNT_WIDTH-1:0]    outstanding_next_s;
    logic                    pulse_r;        // accumulator clear owed this cycle
    logic [2*DATA_WIDTH-1:0] res_data_r;
    logic                    err_r;

    logic                    in_stream_s;
    logic                    accept_s;
    logic                    counting_s;
    logic                    done_s;
    logic                    done_err_s;
    logic                    last_beat_s;
    logic                    row_take_s;
    logic                    err_set_s;

    assign in_stream_s = (state_r == S_STREAM) && !rst;
    assign accept_s    = in_stream_s && elem_valid && mac_in_ready;
    assign counting_s  = (state_r == S_STREAM) || (state_r == S_DRAIN);
    assign done_s      = counting_s && mac_done;
    assign last_beat_s = accept_s && (remaining_r == CNT_WIDTH'(1));
    assign row_take_s  = (state_r == S_IDLE) && row_valid;
    assign err_set_s   = done_err_s ||
                         (mac_done && ((state_r == S_IDLE) || (state_r == S_OUT)));

    // Outstanding-beat bookkeeping: accept and done in one cycle cancel out;
    // a done with nothing in flight is a protocol error.
    always_comb begin
        outstanding_next_s = outstanding_r;
        done_err_s         = 1'b0;
        if (accept_s && !done_s) begin
            outstanding_next_s = outstanding_r + CNT_WIDTH'(1);
        end else if (done_s && !accept_s) begin
            if (outstanding_r == CNT_WIDTH'(0)) begin
                done_err_s = 1'b1;
            end else begin
                outstanding_next_s = outstanding_r - CNT_WIDTH'(1);
            end
        end else begin
            outstanding_next_s = outstanding_r;
        end
    end

    // State register; the clear pulse is re-armed on reset and on READ->CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_INIT;
            pulse_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            pulse_r <= (state_r == S_READ) && (state_next_s == S_CLEAR);
        end
    end

    // Next-state logic; DRAIN is skipped when nothing is left in flight.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_INIT: begin
                if (mac_done) state_next_s = S_IDLE;
                else          state_next_s = S_INIT;
            end
            S_IDLE: begin
                if (row_valid) begin
                    if (row_nnz == CNT_WIDTH'(0)) state_next_s = S_OUT;
                    else                          state_next_s = S_STREAM;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_STREAM: begin
                if (last_beat_s) begin
                    if (outstanding_next_s == CNT_WIDTH'(0)) state_next_s = S_READ;
                    else                                     state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (outstanding_r == CNT_WIDTH'(0)) state_next_s = S_READ;
                else                                state_next_s = S_DRAIN;
            end
            S_READ: begin
                if (mac_valid) state_next_s = S_CLEAR;
                else           state_next_s = S_READ;
            end
            S_CLEAR: begin
                if (mac_done) state_next_s = S_OUT;
                else          state_next_s = S_CLEAR;
            end
            S_OUT: begin
                if (res_ready) state_next_s = S_IDLE;
                else           state_next_s = S_OUT;
            end
            default: state_next_s = S_INIT;
        endcase
    end

    // Output decode; every handshake output is held at its idle value while rst is high.
    always_comb begin
        row_ready    = !rst && (state_r == S_IDLE);
        elem_ready   = in_stream_s && mac_in_ready;
        mac_in_valid = in_stream_s && elem_valid;
        mac_val      = elem_val;
        mac_mult     = elem_mult;
        mac_reset    = pulse_r && !rst;
        mac_ready    = !rst && (state_r == S_READ);
        res_valid    = !rst && (state_r == S_OUT);
        res_data     = rst ? {(2*DATA_WIDTH){1'b0}} : res_data_r;
        busy         = rst || (state_r != S_IDLE);
        err          = err_r && !rst;
    end

    // Beat counters: loaded on descriptor accept, stepped by accepts and dones.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_r   <= CNT_WIDTH'(0);
            outstanding_r <= CNT_WIDTH'(0);
        end else if (row_take_s) begin
            remaining_r   <= row_nnz;
            outstanding_r <= CNT_WIDTH'(0);
        end else begin
            remaining_r   <= accept_s ? (remaining_r - CNT_WIDTH'(1)) : remaining_r;
            outstanding_r <= counting_s ? outstanding_next_s : outstanding_r;
        end
    end

    // Result capture and sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_r <= {(2*DATA_WIDTH){1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (row_take_s && (row_nnz == CNT_WIDTH'(0))) begin
                res_data_r <= {(2*DATA_WIDTH){1'b0}};
            end else if ((state_r == S_READ) && mac_valid) begin
                res_data_r <= mac_acc;
            end else begin
                res_data_r <= res_data_r;
            end
            err_r <= err_r || err_set_s;
        end
    end

endmodule

// File: tb/tb_fmac_driver.sv
// tb_fmac_driver: randomized scoreboard bench for fmac_driver with a
// behavioural fmac (configurable done latency, acc = sum of val*mult).
module tb_fmac_driver;
    localparam int DW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CW-1:0]   row_nnz = '0;
    logic            row_valid = 1'b0;
    logic            row_ready;
    logic [2*DW-1:0] elem_val = '0;
    logic [DW-1:0]   elem_mult = '0;
    logic            elem_valid = 1'b0;
    logic            elem_ready;
    logic [2*DW-1:0] mac_val;
    logic [DW-1:0]   mac_mult;
    logic            mac_in_valid;
    logic            mac_in_ready = 1'b0;
    logic            mac_reset;
    logic [2*DW-1:0] mac_acc;
    logic            mac_valid = 1'b0;
    logic            mac_ready;
    logic            mac_done;
    logic [2*DW-1:0] res_data;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    fmac_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .row_nnz(row_nnz), .row_valid(row_valid), .row_ready(row_ready),
        .elem_val(elem_val), .elem_mult(elem_mult),
        .elem_valid(elem_valid), .elem_ready(elem_ready),
        .mac_val(mac_val), .mac_mult(mac_mult),
        .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready),
        .mac_reset(mac_reset), .mac_acc(mac_acc),
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_done(mac_done),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .err(err)
    );

    typedef struct { logic [63:0] sum; int nnz; } exp_t;
    typedef struct { logic [63:0] v; logic [31:0] m; } elem_t;

    exp_t  exp_q[$];
    elem_t elem_q[$];
    int    row_q[$];

    int checks = 0;
    int passes = 0;

    // stimulus knobs (percent probabilities) and fmac model state
    int          p_elem = 100, p_mready = 100, p_res = 100, p_mvalid = 100;
    int          lat = 2;
    logic        inj_done = 1'b0;
    logic [63:0] acc = '0;
    logic [7:0]  dpipe = '0;
    logic        f_acc = 1'b0, f_rst = 1'b0, f_rstin = 1'b1;
    logic [63:0] f_val = '0;
    logic [31:0] f_mult = '0;
    logic        row_fire = 1'b0, elem_fire = 1'b0;

    assign mac_acc  = acc;
    assign mac_done = inj_done |
                      ((lat == 0) ? ((mac_in_valid & mac_in_ready) | mac_reset) : dpipe[0]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic add_row(input int nnz, input bit rnd, input logic [63:0] base);
        exp_t  e;
        elem_t el;
        e.sum = '0;
        e.nnz = nnz;
        for (int i = 0; i < nnz; i++) begin
            if (rnd) begin
                el.v = {32'h0, $urandom};
                el.m = 32'($urandom_range(0, 65535));
            end else begin
                el.v = base + 64'(i);
                el.m = 32'd1;
            end
            e.sum = e.sum + el.v * 64'(el.m);
            elem_q.push_back(el);
        end
        exp_q.push_back(e);
        row_q.push_back(nnz);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL %s: %0d results pending after %0d cycles, required 0",
                      name, exp_q.size(), budget);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        #4;
        while (busy && (n < budget)) begin
            @(negedge clk);
            #4;
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_values();
        check("rst_row_ready", 64'(row_ready), 64'd0);
        check("rst_elem_ready", 64'(elem_ready), 64'd0);
        check("rst_mac_in_valid", 64'(mac_in_valid), 64'd0);
        check("rst_mac_reset", 64'(mac_reset), 64'd0);
        check("rst_mac_ready", 64'(mac_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
    endtask

    // Driver: behavioural fmac update, then fresh inputs, then handshake capture.
    initial begin
        forever begin
            @(negedge clk);
            if (f_rstin) begin
                acc   = '0;
                dpipe = '0;
            end else begin
                if (f_rst) acc = '0;
                else if (f_acc) acc = acc + f_val * 64'(f_mult);
                dpipe = dpipe >> 1;
                if ((f_acc || f_rst) && (lat > 0)) dpipe[lat-1] = 1'b1;
            end
            if (row_fire) void'(row_q.pop_front());
            if (elem_fire) void'(elem_q.pop_front());
            row_valid = (row_q.size() > 0);
            row_nnz   = row_valid ? CW'(row_q[0]) : '0;
            elem_valid = (elem_q.size() > 0) && ($urandom_range(99) < p_elem);
            if (elem_q.size() > 0) begin
                elem_val  = elem_q[0].v;
                elem_mult = elem_q[0].m;
            end
            mac_in_ready = ($urandom_range(99) < p_mready);
            res_ready    = ($urandom_range(99) < p_res);
            mac_valid    = ($urandom_range(99) < p_mvalid);
            #3;
            row_fire  = row_valid & row_ready;
            elem_fire = elem_valid & elem_ready;
            f_acc     = mac_in_valid & mac_in_ready;
            f_rst     = mac_reset;
            f_val     = mac_val;
            f_mult    = mac_mult;
            f_rstin   = rst;
        end
    end

    // Monitor: element path transparency, result scoreboard, hold and latency rules.
    initial begin
        int          cyc;
        int          acc_cyc;
        int          last_nnz;
        int          beats;
        int          resets;
        bit          active;
        bit          prev_hold;
        bit          prev_resv;
        logic [63:0] prev_data;
        exp_t        e;
        cyc = 0; acc_cyc = 0; last_nnz = -1; beats = 0; resets = 0;
        active = 0; prev_hold = 0; prev_resv = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (rst) begin
                beats = 0; resets = 0; active = 0; prev_hold = 0; prev_resv = 0;
            end else begin
                if ((elem_valid & elem_ready) | (mac_in_valid & mac_in_ready)) begin
                    check("beat_handshake", 64'(mac_in_valid & mac_in_ready),
                          64'(elem_valid & elem_ready));
                    check("beat_val", mac_val, elem_val);
                    check("beat_mult", 64'(mac_mult), 64'(elem_mult));
                end
                if (mac_in_valid && mac_in_ready) beats++;
                if (mac_reset && active) resets++;
                if (row_valid && row_ready) begin
                    active = 1; acc_cyc = cyc; last_nnz = int'(row_nnz);
                    beats = 0; resets = 0;
                end
                if (res_valid && !prev_resv && (last_nnz == 0))
                    check("zero_row_latency", 64'(cyc - acc_cyc), 64'd1);
                if (prev_hold) begin
                    check("res_hold_valid", 64'(res_valid), 64'd1);
                    check("res_hold_data", res_data, prev_data);
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_result: actual %0h, required no result", res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", res_data, e.sum);
                        check("beat_count", 64'(beats), 64'(e.nnz));
                        check("clear_pulses", 64'(resets), (e.nnz > 0) ? 64'd1 : 64'd0);
                    end
                    active = 0;
                    last_nnz = -1;
                end
                prev_hold = res_valid && !res_ready;
                prev_data = res_data;
                prev_resv = res_valid;
            end
        end
    end

    // Watchdog bound on the whole run.
    initial begin
        #800000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "timeout");
    end

    // Test sequence.
    initial begin
        int n;
        repeat (3) @(negedge clk);
        #4;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("init_pulse", 64'(mac_reset), 64'd1);
        @(negedge clk);
        #4;
        check("init_pulse_width", 64'(mac_reset), 64'd0);
        wait_idle("init_to_idle", 50);

        // directed rows: 1+2+3, 1+2, then an empty row
        add_row(3, 1'b0, 64'd1);
        add_row(2, 1'b0, 64'd1);
        add_row(0, 1'b0, 64'd0);
        wait_empty("directed_rows", 200);
        check("err_directed", 64'(err), 64'd0);

        // random handshakes, 100 rows
        p_elem = 60; p_mready = 60; p_res = 50; p_mvalid = 70;
        for (int r = 0; r < 100; r++) add_row($urandom_range(1, 8), 1'b1, 64'd0);
        wait_empty("random_rows", 20000);
        check("err_random", 64'(err), 64'd0);

        // zero done latency
        lat = 0;
        for (int r = 0; r < 20; r++) add_row($urandom_range(0, 8), 1'b1, 64'd0);
        wait_empty("lat0_rows", 5000);
        check("err_lat0", 64'(err), 64'd0);

        // extra done while the result waits in OUT
        lat = 2; p_elem = 100; p_mready = 100; p_mvalid = 100; p_res = 0;
        @(negedge clk);
        add_row(1, 1'b1, 64'd0);
        n = 0;
        #4;
        while (!res_valid && (n < 200)) begin
            @(negedge clk);
            #4;
            n++;
        end
        check("out_reached", 64'(res_valid), 64'd1);
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        #4;
        check("err_set", 64'(err), 64'd1);
        check("out_held", 64'(res_valid), 64'd1);
        p_res = 100;
        wait_empty("inject_row", 200);
        repeat (5) @(negedge clk);
        #4;
        check("err_sticky", 64'(err), 64'd1);

        // reset after 2 of 5 beats
        row_q.push_back(5);
        for (int i = 0; i < 2; i++) begin
            elem_q.push_back('{v: 64'd9, m: 32'd1});
        end
        repeat (20) @(negedge clk);
        #4;
        check("abort_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("reinit_pulse", 64'(mac_reset), 64'd1);
        wait_idle("reinit_to_idle", 50);
        add_row(1, 1'b0, 64'd4);
        wait_empty("post_abort_row", 200);
        check("err_after_rst", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
